// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read RAM port between instruction fetch and load/store.
// Data wins conflicts unless fetch has lost MAX_WAIT cycles in a row; read data returns one cycle later.
module mem_port_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_WAIT   = 3,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  inst_req_i,
   input  logic [ADDR_WIDTH-1:0] inst_addr_i,
   output logic                  inst_gnt_o,
   output logic                  inst_rvalid_o,
   output logic [DATA_WIDTH-1:0] inst_rdata_o,
   input  logic                  data_req_i,
   input  logic                  data_we_i,
   input  logic [ADDR_WIDTH-1:0] data_addr_i,
   input  logic [DATA_WIDTH-1:0] data_wdata_i,
   output logic                  data_gnt_o,
   output logic                  data_rvalid_o,
   output logic [DATA_WIDTH-1:0] data_rdata_o,
   output logic                  ram_ce_o,
   output logic                  ram_we_o,
   output logic [ADDR_WIDTH-1:0] ram_addr_o,
   output logic [DATA_WIDTH-1:0] ram_wdata_o,
   input  logic [DATA_WIDTH-1:0] ram_rdata_i,
   output logic                  stall_if_o,
   output logic                  stall_mem_o,
   output logic [CNT_WIDTH-1:0]  conflict_cnt_o
);

   localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

   typedef enum logic [1:0] {OWN_NONE, OWN_INST, OWN_DATA} owner_e;

   logic [3:0]           starve_q, starve_d;
   owner_e               owner_q, owner_d;
   logic [CNT_WIDTH-1:0] conflict_q, conflict_d;
   logic                 inst_gnt, data_gnt;

   // Grants are held low during reset so nothing reaches the RAM.
   always_comb begin
      inst_gnt = 1'b0;
      data_gnt = 1'b0;
      if (!rst_i) begin
         if (inst_req_i && data_req_i) begin
            inst_gnt = (starve_q == MAX_W);
            data_gnt = (starve_q != MAX_W);
         end else begin
            inst_gnt = inst_req_i;
            data_gnt = data_req_i;
         end
      end
   end

   always_comb begin
      starve_d   = starve_q;
      owner_d    = OWN_NONE;
      conflict_d = conflict_q;
      if (inst_gnt || !inst_req_i) begin
         starve_d = 4'd0;
      end else if (data_gnt && starve_q != MAX_W) begin
         starve_d = starve_q + 4'd1;
      end
      if (inst_gnt) begin
         owner_d = OWN_INST;
      end else if (data_gnt && !data_we_i) begin
         owner_d = OWN_DATA;
      end
      if (inst_req_i && data_req_i && conflict_q != '1) begin
         conflict_d = conflict_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         starve_q   <= 4'd0;
         owner_q    <= OWN_NONE;
         conflict_q <= '0;
      end else begin
         starve_q   <= starve_d;
         owner_q    <= owner_d;
         conflict_q <= conflict_d;
      end
   end

   always_comb begin
      inst_gnt_o     = inst_gnt;
      data_gnt_o     = data_gnt;
      ram_ce_o       = inst_gnt | data_gnt;
      ram_we_o       = data_gnt & data_we_i;
      ram_addr_o     = '0;
      ram_wdata_o    = '0;
      if (inst_gnt) begin
         ram_addr_o = inst_addr_i;
      end else if (data_gnt) begin
         ram_addr_o  = data_addr_i;
         ram_wdata_o = data_wdata_i;
      end
      inst_rvalid_o  = (owner_q == OWN_INST);
      data_rvalid_o  = (owner_q == OWN_DATA);
      inst_rdata_o   = inst_rvalid_o ? ram_rdata_i : '0;
      data_rdata_o   = data_rvalid_o ? ram_rdata_i : '0;
      stall_if_o     = inst_req_i & ~inst_gnt & ~rst_i;
      stall_mem_o    = data_req_i & ~data_gnt & ~rst_i;
      conflict_cnt_o = conflict_q;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small synchronous-read RAM attached.
module tb_mem_port_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        inst_req_i;
   logic [31:0] inst_addr_i;
   logic        inst_gnt_o, inst_rvalid_o;
   logic [31:0] inst_rdata_o;
   logic        data_req_i, data_we_i;
   logic [31:0] data_addr_i, data_wdata_i;
   logic        data_gnt_o, data_rvalid_o;
   logic [31:0] data_rdata_o;
   logic        ram_ce_o, ram_we_o;
   logic [31:0] ram_addr_o, ram_wdata_o;
   logic [31:0] ram_rdata_i;
   logic        stall_if_o, stall_mem_o;
   logic [3:0]  conflict_cnt_o;

   int total = 0;
   int bad   = 0;

   logic [31:0] mem [0:255];

   always #5 clk_i = ~clk_i;

   mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_WAIT(3), .CNT_WIDTH(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .inst_req_i(inst_req_i), .inst_addr_i(inst_addr_i), .inst_gnt_o(inst_gnt_o),
      .inst_rvalid_o(inst_rvalid_o), .inst_rdata_o(inst_rdata_o),
      .data_req_i(data_req_i), .data_we_i(data_we_i), .data_addr_i(data_addr_i),
      .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
      .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
      .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
      .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i),
      .stall_if_o(stall_if_o), .stall_mem_o(stall_mem_o),
      .conflict_cnt_o(conflict_cnt_o)
   );

   // RAM: write in the issue cycle, read data registered for the next cycle.
   always @(posedge clk_i) begin
      if (ram_ce_o && ram_we_o) mem[ram_addr_o[9:2]] <= ram_wdata_o;
      if (ram_ce_o && !ram_we_o) ram_rdata_i <= mem[ram_addr_o[9:2]];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; inputs are then changed and checked before the following edge.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      inst_req_i = 0; inst_addr_i = 0;
      data_req_i = 0; data_we_i = 0; data_addr_i = 0; data_wdata_i = 0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33;
      ram_rdata_i = 32'h0;
      idle_inputs();

      // Reset with both requesters active
      rst_i = 1; inst_req_i = 1; data_req_i = 1; inst_addr_i = 32'h40; data_addr_i = 32'h80;
      tick(); tick();
      chk("rst_inst_gnt", 32'(inst_gnt_o), 32'd0);
      chk("rst_data_gnt", 32'(data_gnt_o), 32'd0);
      chk("rst_ce", 32'(ram_ce_o), 32'd0);
      chk("rst_we", 32'(ram_we_o), 32'd0);
      chk("rst_stalls", {30'd0, stall_if_o, stall_mem_o}, 32'd0);
      chk("rst_rvalid", {30'd0, inst_rvalid_o, data_rvalid_o}, 32'd0);
      chk("rst_addr", ram_addr_o, 32'd0);
      chk("rst_conflict", 32'(conflict_cnt_o), 32'd0);
      rst_i = 0; #1;
      chk("post_rst_data_gnt", 32'(data_gnt_o), 32'd1);
      chk("post_rst_inst_gnt", 32'(inst_gnt_o), 32'd0);
      chk("post_rst_stall_if", 32'(stall_if_o), 32'd1);
      chk("post_rst_addr", ram_addr_o, 32'h80);
      tick();
      idle_inputs();

      // Fetch only, back-to-back
      rst_i = 1; #1; rst_i = 0;
      tick();
      inst_req_i = 1; inst_addr_i = 32'h0; #1;
      chk("f0_gnt", 32'(inst_gnt_o), 32'd1);
      chk("f0_stall", 32'(stall_if_o), 32'd0);
      chk("f0_rvalid", 32'(inst_rvalid_o), 32'd0);
      tick();
      inst_addr_i = 32'h4; #1;
      chk("f1_gnt", 32'(inst_gnt_o), 32'd1);
      chk("f1_rvalid", 32'(inst_rvalid_o), 32'd1);
      chk("f1_rdata", inst_rdata_o, 32'h11);
      chk("f1_addr", ram_addr_o, 32'h4);
      tick();
      inst_addr_i = 32'h8; #1;
      chk("f2_gnt", 32'(inst_gnt_o), 32'd1);
      chk("f2_rdata", inst_rdata_o, 32'h22);
      chk("f2_stall", 32'(stall_if_o), 32'd0);
      chk("f2_data_rvalid", 32'(data_rvalid_o), 32'd0);
      tick();
      inst_req_i = 0; #1;
      chk("f3_rvalid", 32'(inst_rvalid_o), 32'd1);
      chk("f3_rdata", inst_rdata_o, 32'h33);
      chk("f3_ce_idle", 32'(ram_ce_o), 32'd0);
      chk("f3_addr_idle", ram_addr_o, 32'd0);
      tick();
      chk("f4_rvalid", 32'(inst_rvalid_o), 32'd0);
      chk("f4_rdata", inst_rdata_o, 32'd0);

      // Store then load
      data_req_i = 1; data_we_i = 1; data_addr_i = 32'h100; data_wdata_i = 32'hDEADBEEF; #1;
      chk("st_gnt", 32'(data_gnt_o), 32'd1);
      chk("st_we", 32'(ram_we_o), 32'd1);
      chk("st_addr", ram_addr_o, 32'h100);
      chk("st_wdata", ram_wdata_o, 32'hDEADBEEF);
      tick();
      data_we_i = 0; data_wdata_i = 32'h0; #1;
      chk("ld_gnt", 32'(data_gnt_o), 32'd1);
      chk("ld_we", 32'(ram_we_o), 32'd0);
      chk("st_no_rvalid", 32'(data_rvalid_o), 32'd0);
      tick();
      data_req_i = 0; #1;
      chk("ld_rvalid", 32'(data_rvalid_o), 32'd1);
      chk("ld_rdata", data_rdata_o, 32'hDEADBEEF);
      chk("ld_inst_rdata", inst_rdata_o, 32'd0);
      tick();

      // Starvation: D D D I D D D I
      rst_i = 1; #1; rst_i = 0;
      tick();
      inst_req_i = 1; inst_addr_i = 32'h8; data_req_i = 1; data_we_i = 0; data_addr_i = 32'h0;
      for (int c = 0; c < 8; c++) begin
         logic exp_i;
         exp_i = (c == 3) || (c == 7);
         #1;
         chk($sformatf("sv_inst_gnt_%0d", c), 32'(inst_gnt_o), 32'(exp_i));
         chk($sformatf("sv_data_gnt_%0d", c), 32'(data_gnt_o), 32'(!exp_i));
         chk($sformatf("sv_stall_if_%0d", c), 32'(stall_if_o), 32'(!exp_i));
         chk($sformatf("sv_stall_mem_%0d", c), 32'(stall_mem_o), 32'(exp_i));
         chk($sformatf("sv_addr_%0d", c), ram_addr_o, exp_i ? 32'h8 : 32'h0);
         tick();
      end
      chk("sv_conflict8", 32'(conflict_cnt_o), 32'd8);
      chk("sv_rvalid_last", 32'(inst_rvalid_o), 32'd1);
      chk("sv_rdata_last", inst_rdata_o, 32'h33);
      idle_inputs();
      tick();

      // Reset mid-read
      data_req_i = 1; data_we_i = 0; data_addr_i = 32'h100; #1;
      chk("mr_gnt", 32'(data_gnt_o), 32'd1);
      #1; rst_i = 1; #1;
      chk("mr_gnt_in_rst", 32'(data_gnt_o), 32'd0);
      tick();
      chk("mr_rvalid_in_rst", 32'(data_rvalid_o), 32'd0);
      data_req_i = 0;
      rst_i = 0; #1;
      chk("mr_rvalid_after", 32'(data_rvalid_o), 32'd0);
      tick();
      chk("mr_rvalid_after2", 32'(data_rvalid_o), 32'd0);
      chk("mr_rdata_after", data_rdata_o, 32'd0);

      // Conflict counter saturation
      inst_req_i = 1; data_req_i = 1;
      for (int c = 0; c < 20; c++) tick();
      chk("sat_20", 32'(conflict_cnt_o), 32'd15);
      tick(); tick();
      chk("sat_hold", 32'(conflict_cnt_o), 32'd15);
      idle_inputs();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #50000;
      bad++;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule
